pc_branch_unit: RTL and testbench
=================================

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

Interface
REQ-001 The module SHALL have parameter PC_W, default 8, program counter width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, number of return-address stack entries.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port en, input, 1 bit: instruction valid/advance strobe.
REQ-006 The module SHALL have port op, input, 5 bits: instruction opcode.
REQ-007 The module SHALL have port sel, input, 3 bits: flag index tested by BRF.
REQ-008 The module SHALL have port pol, input, 1 bit: flag value that makes BRF taken.
REQ-009 The module SHALL have port target, input, PC_W bits: absolute jump/call destination.
REQ-010 The module SHALL have port flags, input, 8 bits: registered flag-register output (bit0 Z, bit1 O, bit2 N, bit3 C, bit5 A).
REQ-011 The module SHALL have port pc, output, PC_W bits: current program counter.
REQ-012 The module SHALL have port flush, output, 1 bit: one-cycle pulse, fetched instruction is stale.
REQ-013 The module SHALL have port halted, output, 1 bit: state is HALT.
REQ-014 The module SHALL have port fault, output, 1 bit: state is FAULT.
REQ-015 The module SHALL have port depth, output, $clog2(DEPTH)+1 bits: occupied stack entries.

Function
REQ-016 Opcodes SHALL be: JMP 5'h1B, BRF 5'h1C, CALL 5'h1D, RET 5'h1E, HLT 5'h1F; every other opcode is SEQ (sequential).
REQ-017 The FSM SHALL have states RUN, HALT, FAULT; the only exit from HALT or FAULT is reset.
REQ-018 In RUN with en=0, pc, stack, depth and state SHALL hold, and flush SHALL be 0 next cycle.
REQ-019 In RUN with en=1 and SEQ, pc SHALL become pc+1 modulo 2^PC_W (all-ones wraps to 0).
REQ-020 In RUN with en=1 and JMP, pc SHALL become target.
REQ-021 In RUN with en=1 and BRF, pc SHALL become target if flags[sel]==pol, else pc+1 modulo 2^PC_W.
REQ-022 BRF SHALL use flags as sampled on the same edge; no internal flag copy.
REQ-023 In RUN with en=1 and CALL and depth<DEPTH, the unit SHALL push pc+1 (mod 2^PC_W), increment depth and set pc to target.
REQ-024 In RUN with en=1 and CALL and depth==DEPTH, the unit SHALL enter FAULT with pc, stack and depth unchanged.
REQ-025 In RUN with en=1 and RET and depth>0, the unit SHALL set pc to the top entry and decrement depth (LIFO).
REQ-026 In RUN with en=1 and RET and depth==0, the unit SHALL enter FAULT with pc unchanged.
REQ-027 In RUN with en=1 and HLT, the unit SHALL enter HALT with pc unchanged.
REQ-028 flush SHALL be 1 in exactly the cycle after an edge that took JMP, taken BRF, successful CALL or successful RET; 0 otherwise.
REQ-029 In HALT or FAULT, en and op SHALL be ignored; pc, depth hold; flush=0.
REQ-030 halted and fault SHALL be decoded from the registered state, with no combinational path from inputs.
REQ-031 All state updates SHALL take effect one edge after the sampled en (latency 1).

Reset
REQ-032 When reset=1 at a clock edge, pc SHALL become 0, depth 0, state RUN, flush 0, halted 0, fault 0.
REQ-033 Reset SHALL override en/op in the same cycle, including mid-CALL/RET or in HALT/FAULT.
REQ-034 Stack storage contents SHALL NOT require clearing; depth=0 makes them unreachable.

Verification
REQ-035 Reset, en=1 SEQ x3 -> pc 0,1,2,3; flush stays 0; pc=0xFF + SEQ -> pc 0x00.
REQ-036 flags=8'h21, BRF sel=0 pol=1 target=0x40 -> pc 0x40, flush=1 one cycle; same with pol=0 -> pc+1, flush=0.
REQ-037 At pc=0x10: CALL 0x80, CALL 0x90, RET, RET -> pc 0x80, 0x90, 0x81, 0x11; depth 1,2,1,0.
REQ-038 Five CALLs with DEPTH=4 -> depth 4, fifth edge sets fault=1, pc equals fourth target; RET from reset state -> fault=1.
REQ-039 HLT -> halted=1, subsequent JMP ignored; reset asserted together with a CALL -> pc 0, depth 0, halted 0.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program counter with jump, flag branch, call/return stack and halt/fault states.
// Latency: one edge from sampled en to pc/depth/state; flush is registered.
// Backpressure: none; en=0 holds every register, HALT/FAULT ignore en until reset.
module pc_branch_unit #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [4:0]                 op,
    input  logic [2:0]                 sel,
    input  logic                       pol,
    input  logic [PC_W-1:0]            target,
    input  logic [7:0]                 flags,
    output logic [PC_W-1:0]            pc,
    output logic                       flush,
    output logic                       halted,
    output logic                       fault,
    output logic [$clog2(DEPTH):0]     depth
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [4:0] OP_JMP  = 5'h1B;
    localparam logic [4:0] OP_BRF  = 5'h1C;
    localparam logic [4:0] OP_CALL = 5'h1D;
    localparam logic [4:0] OP_RET  = 5'h1E;
    localparam logic [4:0] OP_HLT  = 5'h1F;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state;
    logic [PC_W-1:0]    stack [DEPTH];
    logic [PC_W-1:0]    pc_inc;
    logic [DW-1:0]      depth_m1;
    logic               full;
    logic               empty;
    logic               active;
    logic               brf_taken;
    logic               do_push;

    assign pc_inc    = pc + 1'b1;
    assign depth_m1  = depth - 1'b1;
    assign full      = (depth == DW'(DEPTH));
    assign empty     = (depth == '0);
    assign active    = (state == RUN) && en;
    assign brf_taken = (flags[sel] == pol);
    assign do_push   = active && (op == OP_CALL) && !full;

    assign halted = (state == HALT);
    assign fault  = (state == FAULT);

    // Storage is never cleared; entries above depth are unreachable.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            stack[depth[AW-1:0]] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            depth <= '0;
            state <= RUN;
            flush <= 1'b0;
        end else begin
            flush <= 1'b0;
            if (active) begin
                case (op)
                    OP_JMP: begin
                        pc    <= target;
                        flush <= 1'b1;
                    end
                    OP_BRF: begin
                        pc    <= brf_taken ? target : pc_inc;
                        flush <= brf_taken;
                    end
                    OP_CALL: begin
                        if (full) begin
                            state <= FAULT;
                        end else begin
                            pc    <= target;
                            depth <= depth + 1'b1;
                            flush <= 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (empty) begin
                            state <= FAULT;
                        end else begin
                            pc    <= stack[depth_m1[AW-1:0]];
                            depth <= depth_m1;
                            flush <= 1'b1;
                        end
                    end
                    OP_HLT: state <= HALT;
                    default: pc <= pc_inc;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed and randomized bench for pc_branch_unit against a queue-based reference model.
module tb_pc_branch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [4:0] op;
    logic [2:0] sel;
    logic       pol;
    logic [7:0] target;
    logic [7:0] flags;
    logic [7:0] pc;
    logic       flush;
    logic       halted;
    logic       fault;
    logic [2:0] depth;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int m_pc;
    int m_stk[$];
    int m_st;          // 0 run, 1 halt, 2 fault
    int m_flush;

    pc_branch_unit #(.PC_W(8), .DEPTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .op     (op),
        .sel    (sel),
        .pol    (pol),
        .target (target),
        .flags  (flags),
        .pc     (pc),
        .flush  (flush),
        .halted (halted),
        .fault  (fault),
        .depth  (depth)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model(input logic r, input logic e, input logic [4:0] o,
                         input logic [2:0] s, input logic p, input logic [7:0] t,
                         input logic [7:0] f);
        if (r) begin
            m_pc = 0; m_stk.delete(); m_st = 0; m_flush = 0;
        end else begin
            m_flush = 0;
            if (m_st == 0 && e) begin
                case (o)
                    5'h1B: begin m_pc = t; m_flush = 1; end
                    5'h1C: if (f[s] == p) begin m_pc = t; m_flush = 1; end
                           else m_pc = (m_pc + 1) % 256;
                    5'h1D: if (m_stk.size() < 4) begin
                               m_stk.push_back((m_pc + 1) % 256);
                               m_pc = t; m_flush = 1;
                           end else m_st = 2;
                    5'h1E: if (m_stk.size() > 0) begin
                               m_pc = m_stk.pop_back(); m_flush = 1;
                           end else m_st = 2;
                    5'h1F: m_st = 1;
                    default: m_pc = (m_pc + 1) % 256;
                endcase
            end
        end
    endtask

    // Drive one cycle, advance the model, then compare every output 1ns after the edge.
    task automatic step(input logic r, input logic e, input logic [4:0] o,
                        input logic [2:0] s, input logic p, input logic [7:0] t,
                        input logic [7:0] f);
        reset = r; en = e; op = o; sel = s; pol = p; target = t; flags = f;
        @(posedge clk);
        model(r, e, o, s, p, t, f);
        #1;
        check("pc",     32'(pc),     32'(m_pc));
        check("depth",  32'(depth),  32'(m_stk.size()));
        check("flush",  32'(flush),  32'(m_flush));
        check("halted", 32'(halted), 32'(m_st == 1));
        check("fault",  32'(fault),  32'(m_st == 2));
    endtask

    task automatic rst();
        step(1, 0, 5'h00, 0, 0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [4:0] o;
        reset = 1'b1; en = 1'b0; op = '0; sel = '0; pol = 1'b0; target = '0; flags = '0;

        rst();
        check("reset_pc", 32'(pc), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 5'h00, 0, 0, 8'h00, 8'h00);
        check("seq3_pc", 32'(pc), 32'h3);
        step(0, 1, 5'h1B, 0, 0, 8'hFF, 8'h00);
        step(0, 1, 5'h05, 0, 0, 8'h00, 8'h00);
        check("wrap_pc", 32'(pc), 32'h0);

        step(0, 1, 5'h1C, 3'd0, 1, 8'h40, 8'h21);
        check("brf_taken_pc", 32'(pc), 32'h40);
        check("brf_taken_flush", 32'(flush), 32'h1);
        step(0, 1, 5'h1C, 3'd0, 0, 8'h40, 8'h21);
        check("brf_nt_pc", 32'(pc), 32'h41);
        check("brf_nt_flush", 32'(flush), 32'h0);
        step(0, 0, 5'h1B, 0, 0, 8'h77, 8'h00);
        check("hold_pc", 32'(pc), 32'h41);

        step(0, 1, 5'h1B, 0, 0, 8'h10, 8'h00);
        step(0, 1, 5'h1D, 0, 0, 8'h80, 8'h00);
        step(0, 1, 5'h1D, 0, 0, 8'h90, 8'h00);
        check("call2_depth", 32'(depth), 32'h2);
        step(0, 1, 5'h1E, 0, 0, 8'h00, 8'h00);
        check("ret1_pc", 32'(pc), 32'h81);
        step(0, 1, 5'h1E, 0, 0, 8'h00, 8'h00);
        check("ret2_pc", 32'(pc), 32'h11);

        rst();
        for (int i = 0; i < 5; i++) step(0, 1, 5'h1D, 0, 0, 8'(8'h20 + i), 8'h00);
        check("ovf_fault", 32'(fault), 32'h1);
        check("ovf_pc", 32'(pc), 32'h23);
        check("ovf_depth", 32'(depth), 32'h4);
        rst();
        step(0, 1, 5'h1E, 0, 0, 8'h00, 8'h00);
        check("unf_fault", 32'(fault), 32'h1);

        rst();
        step(0, 1, 5'h1F, 0, 0, 8'h00, 8'h00);
        step(0, 1, 5'h1B, 0, 0, 8'h55, 8'h00);
        check("halt_ignore_pc", 32'(pc), 32'h0);
        step(1, 1, 5'h1D, 0, 0, 8'h66, 8'h00);
        check("rst_call_halted", 32'(halted), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            o = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0) o = 5'($urandom_range(5'h1A, 5'h1E));
            if (o == 5'h1F && $urandom_range(0, 7) != 0) o = 5'h00;
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), o,
                 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
